// File: rtl/alu_seq_if.sv
// Operation request and result channels of alu_seq, each with valid/ready.
// master drives requests and takes results; slave is the ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             car;
    logic             of;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, res, car, of, zero, err
    );

    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, res, car, of, zero, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: one-at-a-time WIDTH-bit ALU with a shift-add multiplier.
// Latency: result valid 1 cycle after accept, WIDTH+1 cycles for mul.
// Backpressure: result held in DONE until out_ready; no request accepted outside IDLE.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_NOT = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SLT = 4'h6;
    localparam logic [3:0] OP_SEQ = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SRL = 4'h9;
    localparam logic [3:0] OP_SRA = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             car;
        logic             of;
        logic             zero;
        logic             err;
    } result_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] partial;
    result_t            out_q;
    result_t            alu_r;
    result_t            mul_r;
    logic               accept;
    logic               is_mul;
    logic               last;
    logic [SHW-1:0]     s;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;

    assign is_mul = (bus.ctrl == OP_MUL);
    assign accept = (state_q == IDLE) && bus.in_valid;
    // WIDTH is a power of two, so the final iteration is the all-ones count.
    assign last   = &cnt_q;
    assign s      = bus.b[SHW-1:0];

    // Single-cycle ops are evaluated straight off the bus and latched on the accept edge.
    always_comb begin
        alu_r = '0;
        sum   = '0;
        shl   = '0;
        shr   = '0;
        case (bus.ctrl)
            OP_ADD: begin
                sum = {1'b0, bus.a} + {1'b0, bus.b};
                {alu_r.car, alu_r.res} = sum;
                alu_r.of = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
                {alu_r.car, alu_r.res} = sum;
                alu_r.of = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOT: alu_r.res = ~bus.a;
            OP_AND: alu_r.res = bus.a & bus.b;
            OP_OR:  alu_r.res = bus.a | bus.b;
            OP_XOR: alu_r.res = bus.a ^ bus.b;
            OP_SLT: alu_r.res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SEQ: alu_r.res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            // The extra bit beside the operand catches the last bit shifted out.
            OP_SLL: begin
                shl = {1'b0, bus.a} << s;
                {alu_r.car, alu_r.res} = shl;
            end
            OP_SRL: begin
                shr = {bus.a, 1'b0} >> s;
                {alu_r.res, alu_r.car} = shr;
            end
            OP_SRA: begin
                shr = $signed({bus.a, 1'b0}) >>> s;
                {alu_r.res, alu_r.car} = shr;
            end
            OP_MUL: ;
            default: alu_r.err = 1'b1;
        endcase
        alu_r.zero = (alu_r.res == '0);
    end

    assign partial = {{WIDTH{1'b0}}, a_q} << cnt_q;
    assign prod_d  = b_q[cnt_q] ? (prod_q + partial) : prod_q;

    always_comb begin
        mul_r      = '0;
        mul_r.res  = prod_d[WIDTH-1:0];
        mul_r.car  = |prod_d[2*WIDTH-1:WIDTH];
        mul_r.zero = (prod_d[WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = is_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            out_q  <= '0;
        end else begin
            if (accept) begin
                if (is_mul) begin
                    a_q    <= bus.a;
                    b_q    <= bus.b;
                    cnt_q  <= '0;
                    prod_q <= '0;
                end else begin
                    out_q <= alu_r;
                end
            end
            if (state_q == BUSY) begin
                prod_q <= prod_d;
                cnt_q  <= cnt_q + 1'b1;
                if (last) begin
                    out_q <= mul_r;
                end
            end
        end
    end

    assign bus.res  = out_q.res;
    assign bus.car  = out_q.car;
    assign bus.of   = out_q.of;
    assign bus.zero = out_q.zero;
    assign bus.err  = out_q.err;
endmodule
